// File: rtl/fp_round_pack.sv
// fp_round_pack
//   Two-stage rounding and packing stage for an 8-bit minifloat
//   {sign[7], exp[6:4], sig[3:0]}.
//   - S1 registers the word from the normalizer.
//   - The rounded result is computed combinationally from S1.
//   - S2 is the output register.
//   Rounding is round-half-up on the magnitude. A carry out of the
//   significand bumps the exponent. A carry out of exp=7 saturates to the
//   largest magnitude.
//
// Optional feature (macro FP_ROUND_STATS_EN):
//   When defined, sat_count counts saturating words as they move S1->S2.
//   It sticks at 255.
//   When undefined, sat_count is tied to zero and no counter exists.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block accepts a word this cycle (combinational)
//   in_sign    sign of the original value
//   in_exp     exponent 0..7
//   in_sig     truncated 4-bit significand
//   in_fifth   round bit (first magnitude bit below sig LSB)
//   out_valid  out_fp holds a valid result
//   out_ready  downstream consumes the result
//   out_fp     packed rounded float
//   sat_count  number of rounding-induced saturations
module fp_round_pack (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [2:0] in_exp,
  input  logic [3:0] in_sig,
  input  logic       in_fifth,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_fp,
  output logic [7:0] sat_count
);

  logic       s1_valid;
  logic       s1_sign;
  logic [2:0] s1_exp;
  logic [3:0] s1_sig;
  logic       s1_fifth;

  logic       s2_valid;
  logic [7:0] s2_fp;

  logic       s1_adv;
  logic       s2_adv;

  logic [2:0] rnd_exp;
  logic [3:0] rnd_sig;

  // A stage may load when it is empty or when its contents leave this edge.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid;
  assign out_fp    = s2_fp;

  // Round-half-up on the magnitude.
  // - sig=15 with a round bit carries into the exponent.
  // - At exp=7 that carry saturates: exp and sig are left at 7 and 15.
  always_comb begin
    rnd_exp = s1_exp;
    rnd_sig = s1_sig;
    if (s1_fifth) begin
      if (s1_sig != 4'hF) begin
        rnd_sig = s1_sig + 4'd1;
      end else if (s1_exp != 3'd7) begin
        rnd_sig = 4'b1000;
        rnd_exp = s1_exp + 3'd1;
      end
    end
  end

  // S1: capture the incoming word whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= 3'd0;
      s1_sig   <= 4'd0;
      s1_fifth <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_exp   <= in_exp;
        s1_sig   <= in_sig;
        s1_fifth <= in_fifth;
      end
    end
  end

  // S2: the data only changes when a real word arrives.
  // This keeps out_fp stable while the stage is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_fp    <= 8'h00;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_fp <= {s1_sign, rnd_exp, rnd_sig};
      end
    end
  end

`ifdef FP_ROUND_STATS_EN
  logic       sat_event;
  logic [7:0] sat_cnt_q;

  // Only a real carry out of the top exponent counts as a saturation.
  // exp=7, sig=15 without a round bit is already exact.
  assign sat_event = s1_fifth && (s1_sig == 4'hF) && (s1_exp == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= 8'h00;
    end else if (s1_valid && s2_adv && sat_event && (sat_cnt_q != 8'hFF)) begin
      sat_cnt_q <= sat_cnt_q + 8'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = 8'h00;
`endif

endmodule
